sdram_arbiter: RTL

- Shares the single-slot SDRAM controller between three requesters: video (read-only), CPU and DMA.
- One requester is granted per 8 MHz slot, which is 12 clk_96 cycles.
- Mirrors the controller's slot phase, so the controller's req/we/addr/ds/din are presented stable exactly when it samples them.
- Returns the controller's dout to the granted port with a one-cycle ack.

---
 rtl/sdram_arb_pkg.sv | 19 +
 rtl/sdram_arb_rr2.sv | 40 ++++
 rtl/sdram_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: types and constants shared by the SDRAM slot arbiter.
//   grant_t   - which requester owns the current 12-cycle slot.
//   PH_LAST   - last phase value of a slot (phase counts 0..11).
//   PH_DECIDE - phase whose closing edge registers the next slot's grant.
//   PH_ACK    - phase whose closing edge registers the completion ack.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_VID  = 2'd1,
      GNT_CPU  = 2'd2,
      GNT_DMA  = 2'd3
   } grant_t;

   localparam logic [3:0] PH_LAST   = 4'd11;
   localparam logic [3:0] PH_DECIDE = 4'd11;
   localparam logic [3:0] PH_ACK    = 4'd9;

endpackage

// File: rtl/sdram_arb_rr2.sv
// sdram_arb_rr2: two-way round-robin picker between the CPU and DMA ports.
// Ports:
//   clk_96    in  clock
//   reset     in  synchronous active-high reset (last winner := DMA)
//   cpu_req   in  CPU request level
//   dma_req   in  DMA request level
//   update_en in  commit the current pick as the new last winner
//   rr_pick   out combinational pick (GNT_NONE / GNT_CPU / GNT_DMA)
module sdram_arb_rr2
   import sdram_arb_pkg::*;
(
   input  logic   clk_96,
   input  logic   reset,
   input  logic   cpu_req,
   input  logic   dma_req,
   input  logic   update_en,
   output grant_t rr_pick
);

   // 1 = DMA won the last CPU/DMA contention, 0 = CPU did.
   logic rr_last_reg;

   always_comb begin
      rr_pick = GNT_NONE;
      if (cpu_req && dma_req)
         rr_pick = rr_last_reg ? GNT_CPU : GNT_DMA;
      else if (cpu_req)
         rr_pick = GNT_CPU;
      else if (dma_req)
         rr_pick = GNT_DMA;
   end

   always_ff @(posedge clk_96) begin
      if (reset)
         rr_last_reg <= 1'b1;
      else if (update_en && (rr_pick != GNT_NONE))
         rr_last_reg <= (rr_pick == GNT_DMA);
   end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares a single-slot SDRAM controller between a read-only
// video port, a CPU port and a DMA port. One requester owns each 12-cycle
// (8 MHz) slot; the phase counter mirrors the controller's own so the mem_*
// outputs are stable whenever the controller samples them.
// Ports:
//   clk_96, reset            clock / synchronous active-high reset
//   clk_8_en                 8 MHz enable; its rising edge resyncs phase to 10
//   vid_req/addr/ack         video read port
//   cpu_req/we/addr/ds/din/ack, dma_* : CPU and DMA read/write ports
//   port_dout                read data for whichever port is acked
//   mem_req/we/addr/ds/din   to the controller; mem_dout from it
// Optional: define SDRAM_ARB_REFRESH_EN to force a refresh (idle) slot after
// REFRESH_INTERVAL consecutive busy slots.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W           = 24,
   parameter int REFRESH_INTERVAL = 8
) (
   input  logic              clk_96,
   input  logic              reset,
   input  logic              clk_8_en,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [1:0]        cpu_ds,
   input  logic [15:0]       cpu_din,
   output logic              cpu_ack,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [1:0]        dma_ds,
   input  logic [15:0]       dma_din,
   output logic              dma_ack,
   output logic [15:0]       port_dout,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_ds,
   output logic [15:0]       mem_din,
   input  logic [15:0]       mem_dout
);

   localparam grant_t ACK_GNT [3] = '{GNT_VID, GNT_CPU, GNT_DMA};

   logic       clk_8_en_d_reg;
   logic [3:0] ph_reg;
   grant_t     grant_reg;
   grant_t     grant_next;
   grant_t     rr_pick;
   logic       acked_reg;
   logic [2:0] ack_reg;
   logic       decide;
   logic       force_refresh;
   logic       rr_update;

   assign decide = (ph_reg == PH_DECIDE);

`ifdef SDRAM_ARB_REFRESH_EN
   localparam int                BUSY_W   = $clog2(REFRESH_INTERVAL + 1);
   localparam logic [BUSY_W-1:0] BUSY_MAX = BUSY_W'(REFRESH_INTERVAL);

   logic [BUSY_W-1:0] busy_cnt_reg;

   assign force_refresh = (busy_cnt_reg == BUSY_MAX);

   // Counts consecutive granted slots; any idle slot (natural or forced)
   // gives the controller its refresh and restarts the count.
   always_ff @(posedge clk_96) begin
      if (reset)
         busy_cnt_reg <= '0;
      else if (decide) begin
         if (force_refresh || (grant_next == GNT_NONE))
            busy_cnt_reg <= '0;
         else
            busy_cnt_reg <= busy_cnt_reg + 1'b1;
      end
   end
`else
   assign force_refresh = 1'b0;
`endif

   // A forced refresh slot must not disturb the CPU/DMA fairness state.
   assign rr_update = decide && !vid_req && !force_refresh;

   sdram_arb_rr2 u_rr2 (
      .clk_96    (clk_96),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .dma_req   (dma_req),
      .update_en (rr_update),
      .rr_pick   (rr_pick)
   );

   always_comb begin
      grant_next = GNT_NONE;
      if (force_refresh)
         grant_next = GNT_NONE;
      else if (vid_req)
         grant_next = GNT_VID;
      else
         grant_next = rr_pick;
   end

   always_ff @(posedge clk_96) begin
      if (reset) begin
         clk_8_en_d_reg <= 1'b0;
         ph_reg         <= 4'd0;
         grant_reg      <= GNT_NONE;
         acked_reg      <= 1'b0;
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_ds         <= 2'b11;
         mem_din        <= 16'h0000;
      end else begin
         clk_8_en_d_reg <= clk_8_en;

         if (!clk_8_en_d_reg && clk_8_en)
            ph_reg <= 4'd10;
         else if (ph_reg == PH_LAST)
            ph_reg <= 4'd0;
         else
            ph_reg <= ph_reg + 4'd1;

         if (decide) begin
            grant_reg <= grant_next;
            acked_reg <= 1'b0;
            case (grant_next)
               GNT_VID: begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= vid_addr;
                  mem_ds   <= 2'b11;
               end
               GNT_CPU: begin
                  mem_req  <= 1'b1;
                  mem_we   <= cpu_we;
                  mem_addr <= cpu_addr;
                  mem_ds   <= cpu_ds;
                  mem_din  <= cpu_din;
               end
               GNT_DMA: begin
                  mem_req  <= 1'b1;
                  mem_we   <= dma_we;
                  mem_addr <= dma_addr;
                  mem_ds   <= dma_ds;
                  mem_din  <= dma_din;
               end
               default: begin
                  // Idle slot: controller refreshes. Address/data are left
                  // as they were; we is dropped so nothing looks like a write.
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end
            endcase
         end else if ((ph_reg == PH_ACK) && (grant_reg != GNT_NONE)) begin
            acked_reg <= 1'b1;
         end
      end
   end

   // One ack per granted slot, only on a real 9->10 phase step; a resync
   // that jumps past phase 9 simply leaves the slot unacked.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_ack
         always_ff @(posedge clk_96) begin
            if (reset)
               ack_reg[gi] <= 1'b0;
            else
               ack_reg[gi] <= (ph_reg == PH_ACK) && !acked_reg &&
                              (grant_reg == ACK_GNT[gi]);
         end
      end
   endgenerate

   assign vid_ack   = ack_reg[0];
   assign cpu_ack   = ack_reg[1];
   assign dma_ack   = ack_reg[2];
   assign port_dout = mem_dout;

endmodule
